sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, strobe-active cycles per access; legal range 1..15, out-of-range is an elaboration error.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, a CPU access request is present.
REQ-005 SHALL have port req_ready, output, 1, the controller accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = write and 0 = read.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, write data.
REQ-009 SHALL have port resp_valid, output, 1, single-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, read data, valid while resp_valid=1.
REQ-011 SHALL have port resp_err, output, 1, request rejected (see Configuration).
REQ-012 SHALL have ports sram_cs, sram_oe and sram_we, outputs, 1 each, SRAM strobes, all active-high.
REQ-013 SHALL have port sram_addr, output, 32, SRAM address.
REQ-014 SHALL have port sram_din, output, 32, data driven to the SRAM.
REQ-015 SHALL have port sram_dout, input, 32, data returned by the SRAM.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, ACCESS, HOLD and RESP.
REQ-017 SHALL accept a request when req_valid=1 and req_ready=1 on a rising clk edge; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL register req_we, req_addr and req_wdata at acceptance; input changes after acceptance SHALL have no effect.
REQ-019 IDLE SHALL hold all sram_* strobes at 0 and SHALL go to SETUP on acceptance.
REQ-020 SETUP SHALL last 1 cycle, with sram_cs=1, sram_addr/sram_din driven and sram_oe=sram_we=0, then go to ACCESS.
REQ-021 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, with sram_cs=1 and either sram_we=1 (write) or sram_oe=1 (read), never both.
REQ-022 On a read, the controller SHALL capture sram_dout on the clk edge that ends the last ACCESS cycle.
REQ-023 HOLD SHALL last 1 cycle, with sram_cs=1, sram_oe=sram_we=0 and address/data still held.
REQ-024 RESP SHALL last 1 cycle with resp_valid=1 and all strobes 0, then return to IDLE.
REQ-025 resp_valid SHALL assert exactly WAIT_CYCLES+3 cycles after the acceptance edge; there is no backpressure on resp_valid.
REQ-026 resp_rdata SHALL hold the last captured read value until the next read completes; after a write it SHALL be unchanged.
REQ-027 sram_addr and sram_din SHALL stay stable from SETUP through HOLD.
REQ-028 A request held valid during a busy period SHALL be accepted on the first IDLE cycle after RESP, giving a minimum request-to-request spacing of WAIT_CYCLES+4 cycles.

Reset
REQ-029 rst_n=0 SHALL, at any time including mid-ACCESS, immediately force the state to IDLE and all strobes to 0.
REQ-030 During reset, req_ready SHALL be 0, resp_valid=0, resp_err=0, resp_rdata=0, sram_addr=0 and sram_din=0.
REQ-031 A request interrupted by reset SHALL be dropped with no response.
REQ-032 req_ready SHALL become 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-033 With SRAM_CTRL_ALIGN_CHECK_EN defined, an accepted request with req_addr[1:0]!=0 SHALL skip SETUP/ACCESS/HOLD and go directly to RESP with resp_err=1, resp_rdata unchanged and no sram_cs activity.
REQ-034 Without SRAM_CTRL_ALIGN_CHECK_EN, resp_err SHALL be tied to 0 and all addresses SHALL be passed through unchanged.

Structure
REQ-035 Package sram_ctrl_pkg SHALL hold the FSM state typedef, the 4-bit wait-count width constant and the WAIT_CYCLES legal-range constants.
REQ-036 The wait counter SHALL be a sub-module, sram_ctrl_wait_cnt, with load, decrement and zero-flag functions.

Verification
REQ-037 Write test, WAIT_CYCLES=2: write addr 0x00000010, data 0xDEADBEEF -> sram_we high for 2 cycles, sram_din=0xDEADBEEF, resp_valid pulse 5 cycles after acceptance.
REQ-038 Read test: read addr 0x00000010 with the SRAM model returning 0xDEADBEEF -> sram_oe high for 2 cycles, resp_rdata=0xDEADBEEF with resp_valid.
REQ-039 Back-to-back test: req_valid held for two reads (0x4, 0x8) -> req_ready=0 while busy; second acceptance 6 cycles after the first.
REQ-040 Reset test: rst_n pulsed low in the 1st ACCESS cycle -> all strobes 0 in the same cycle, no resp_valid, req_ready=1 one cycle after release.
REQ-041 Alignment test, macro defined: request to 0x00000012 -> resp_err=1 and resp_valid one cycle after acceptance, sram_cs never asserted.
REQ-042 Parameter test, WAIT_CYCLES=15: read -> sram_oe high exactly 15 cycles, resp_valid 18 cycles after acceptance.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM state encoding,
// wait-counter width and the legal WAIT_CYCLES range.
package sram_ctrl_pkg;

   localparam int WCNT_W   = 4;
   localparam int WAIT_MIN = 1;
   localparam int WAIT_MAX = 15;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD,
      RESP
   } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU request/response and SRAM pin bundle. The controller takes the slave
// side; the CPU plus SRAM device model take the master side.
interface sram_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        sram_cs;
   logic        sram_oe;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, sram_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  sram_cs, sram_oe, sram_we, sram_addr, sram_din
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, sram_dout,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output sram_cs, sram_oe, sram_we, sram_addr, sram_din
   );

endinterface

// File: rtl/sram_ctrl_wait_cnt.sv
// Strobe-phase down-counter: load a start value, decrement, flag zero.
// Decrement saturates at zero so a late dec never wraps.
module sram_ctrl_wait_cnt
   import sram_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              dec,
   input  logic [WCNT_W-1:0] load_val,
   output logic              zero
);

   logic [WCNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - WCNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: SETUP / ACCESS x WAIT_CYCLES / HOLD / RESP.
// Define SRAM_CTRL_ALIGN_CHECK_EN to reject word-misaligned requests with resp_err.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input logic        clk,
   input logic        rst_n,
   sram_ctrl_if.slave bus
);

   if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("sram_ctrl: WAIT_CYCLES=%0d outside %0d..%0d", WAIT_CYCLES, WAIT_MIN, WAIT_MAX);
   end

   state_t      state;
   logic        ready_q;
   logic        resp_q;
   logic        cs_q;
   logic        oe_q;
   logic        we_q;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] din_q;
   logic [31:0] rd_buf;
   logic [31:0] rdata_q;
   logic        cnt_zero;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   logic        err_q;
`endif

   // Loaded with WAIT_CYCLES-1 in SETUP, so zero marks the final ACCESS cycle.
   sram_ctrl_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == SETUP),
      .dec      (state == ACCESS),
      .load_val (WCNT_W'(WAIT_CYCLES - 1)),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ready_q <= 1'b0;
         resp_q  <= 1'b0;
         cs_q    <= 1'b0;
         oe_q    <= 1'b0;
         we_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         rd_buf  <= '0;
         rdata_q <= '0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  wr_q    <= bus.req_we;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
                  if (bus.req_addr[1:0] != 2'b00) begin
                     state  <= RESP;
                     resp_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else
`endif
                  begin
                     state  <= SETUP;
                     cs_q   <= 1'b1;
                     addr_q <= bus.req_addr;
                     din_q  <= bus.req_wdata;
                  end
               end else begin
                  // Covers the first edge after reset release as well.
                  ready_q <= 1'b1;
               end
            end
            SETUP: begin
               state <= ACCESS;
               oe_q  <= ~wr_q;
               we_q  <= wr_q;
            end
            ACCESS: begin
               if (cnt_zero) begin
                  state <= HOLD;
                  oe_q  <= 1'b0;
                  we_q  <= 1'b0;
                  if (!wr_q) rd_buf <= bus.sram_dout;
               end
            end
            HOLD: begin
               state  <= RESP;
               cs_q   <= 1'b0;
               resp_q <= 1'b1;
               // Read data becomes visible together with the completion pulse.
               if (!wr_q) rdata_q <= rd_buf;
            end
            RESP: begin
               state   <= IDLE;
               resp_q  <= 1'b0;
               ready_q <= 1'b1;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
               err_q   <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.sram_cs    = cs_q;
   assign bus.sram_oe    = oe_q;
   assign bus.sram_we    = we_q;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_din   = din_q;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   assign bus.resp_err   = err_q;
`else
   assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: WAIT_CYCLES=2 instance for most scenarios, WAIT_CYCLES=15
// instance for the long-strobe case. Reference: word array + last-read register.
module tb_sram_ctrl;

   localparam int W  = 2;
   localparam int WB = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_ctrl_if a();
   sram_ctrl_if b();

   sram_ctrl #(.WAIT_CYCLES(W))  u_dut   (.clk(clk), .rst_n(rst_n), .bus(a));
   sram_ctrl #(.WAIT_CYCLES(WB)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(b));

   // SRAM device models; data out is garbage whenever the output enable is low
   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   always @(posedge clk) begin
      if (a.sram_cs && a.sram_we) mem_a[a.sram_addr[7:2]] <= a.sram_din;
      if (b.sram_cs && b.sram_we) mem_b[b.sram_addr[7:2]] <= b.sram_din;
   end
   assign a.sram_dout = a.sram_oe ? mem_a[a.sram_addr[7:2]] : 32'h0BAD_0BAD;
   assign b.sram_dout = b.sram_oe ? mem_b[b.sram_addr[7:2]] : 32'h0BAD_0BAD;

   // Reference model
   logic [31:0] ref_mem [16];
   logic [31:0] exp_rdata;

   // Observation of instance a, sampled on the falling edge.
   // acc_edge = index of the accepting rising edge; resp_cyc = rising edges seen
   // when resp_valid is observed, so "Nth cycle after acceptance" = resp_cyc-acc_edge+1.
   int          acc_n = 0, resp_n = 0, we_n = 0, oe_n = 0, both_n = 0;
   int          unstab_n = 0, busy_n = 0, cs_rise_n = 0;
   int          acc_edge_a [256];
   int          resp_cyc_a [256];
   logic [31:0] resp_rd_a  [256];
   logic        resp_err_a [256];
   logic        prev_cs = 1'b0;
   logic [31:0] cs_addr = '0, cs_din = '0;

   always @(negedge clk) begin
      if (a.req_valid && a.req_ready) begin
         acc_edge_a[acc_n % 256] <= cyc + 1;
         acc_n <= acc_n + 1;
      end
      if (a.resp_valid) begin
         resp_cyc_a[resp_n % 256] <= cyc;
         resp_rd_a[resp_n % 256]  <= a.resp_rdata;
         resp_err_a[resp_n % 256] <= a.resp_err;
         resp_n <= resp_n + 1;
      end
      if (a.sram_we) we_n <= we_n + 1;
      if (a.sram_oe) oe_n <= oe_n + 1;
      if (a.sram_oe && a.sram_we) both_n <= both_n + 1;
      if (a.sram_cs && !prev_cs) begin
         cs_rise_n <= cs_rise_n + 1;
         cs_addr   <= a.sram_addr;
         cs_din    <= a.sram_din;
      end else if (a.sram_cs && (a.sram_addr !== cs_addr || a.sram_din !== cs_din)) begin
         unstab_n <= unstab_n + 1;
      end
      prev_cs <= a.sram_cs;
      if (a.req_ready && (a.sram_cs || a.resp_valid)) busy_n <= busy_n + 1;
   end

   // Observation of instance b
   int          acc_b_n = 0, resp_b_n = 0, oe_b_n = 0, we_b_n = 0;
   int          acc_b_edge = 0, resp_b_cyc = 0;
   logic [31:0] resp_b_rd = '0;

   always @(negedge clk) begin
      if (b.req_valid && b.req_ready) begin
         acc_b_edge <= cyc + 1;
         acc_b_n    <= acc_b_n + 1;
      end
      if (b.resp_valid) begin
         resp_b_cyc <= cyc;
         resp_b_rd  <= b.resp_rdata;
         resp_b_n   <= resp_b_n + 1;
      end
      if (b.sram_oe) oe_b_n <= oe_b_n + 1;
      if (b.sram_we) we_b_n <= we_b_n + 1;
   end

   task automatic access_a(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input string tag);
      int a0, r0, we0, oe0, both0, un0, bz0, lat;
      bit got;
      a0 = acc_n; r0 = resp_n; we0 = we_n; oe0 = oe_n;
      both0 = both_n; un0 = unstab_n; bz0 = busy_n;
      @(posedge clk); #1;
      a.req_valid = 1'b1; a.req_we = we; a.req_addr = addr; a.req_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = (acc_n != a0); end
      // scramble inputs after acceptance; the captured request must not care
      a.req_valid = 1'b0; a.req_we = 1'($urandom); a.req_addr = $urandom; a.req_wdata = $urandom;
      checks++;
      if (!got) begin errors++; $display("FAIL %s accept: none within 40 cycles", tag); return; end
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = (resp_n != r0); end
      checks++;
      if (!got) begin errors++; $display("FAIL %s resp: none within 40 cycles", tag); return; end
      repeat (2) @(posedge clk);
      #1;
      if (we) ref_mem[addr[5:2]] = wd;
      else    exp_rdata = ref_mem[addr[5:2]];
      lat = resp_cyc_a[r0 % 256] - acc_edge_a[a0 % 256] + 1;
      checks++;
      if (lat != W + 3) begin errors++; $display("FAIL %s latency got %0d exp %0d", tag, lat, W + 3); end
      checks++;
      if (resp_n - r0 != 1) begin errors++; $display("FAIL %s resp_pulses got %0d exp 1", tag, resp_n - r0); end
      checks++;
      if (we_n - we0 != (we ? W : 0)) begin
         errors++; $display("FAIL %s we_cycles got %0d exp %0d", tag, we_n - we0, we ? W : 0);
      end
      checks++;
      if (oe_n - oe0 != (we ? 0 : W)) begin
         errors++; $display("FAIL %s oe_cycles got %0d exp %0d", tag, oe_n - oe0, we ? 0 : W);
      end
      checks++;
      if (both_n != both0 || unstab_n != un0 || busy_n != bz0) begin
         errors++;
         $display("FAIL %s invariants oe&we=%0d unstable=%0d ready_busy=%0d exp 0 0 0",
                  tag, both_n - both0, unstab_n - un0, busy_n - bz0);
      end
      checks++;
      if (cs_addr !== addr) begin errors++; $display("FAIL %s sram_addr got %h exp %h", tag, cs_addr, addr); end
      if (we) begin
         checks++;
         if (cs_din !== wd) begin errors++; $display("FAIL %s sram_din got %h exp %h", tag, cs_din, wd); end
      end
      checks++;
      if (resp_rd_a[r0 % 256] !== exp_rdata) begin
         errors++; $display("FAIL %s resp_rdata got %h exp %h", tag, resp_rd_a[r0 % 256], exp_rdata);
      end
      checks++;
      if (resp_err_a[r0 % 256] !== 1'b0) begin
         errors++; $display("FAIL %s resp_err got %b exp 0", tag, resp_err_a[r0 % 256]);
      end
   endtask

   task automatic test_reset();
      a.req_valid = 1'b0; a.req_we = 1'b0; a.req_addr = '0; a.req_wdata = '0;
      b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      exp_rdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a.req_ready, a.resp_valid, a.resp_err, a.sram_cs, a.sram_oe, a.sram_we} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b rv=%b err=%b cs=%b oe=%b we=%b exp all 0",
                  a.req_ready, a.resp_valid, a.resp_err, a.sram_cs, a.sram_oe, a.sram_we);
      end
      checks++;
      if ({a.resp_rdata, a.sram_addr, a.sram_din} !== 96'b0) begin
         errors++;
         $display("FAIL reset_data got rdata=%h addr=%h din=%h exp 0", a.resp_rdata, a.sram_addr, a.sram_din);
      end
      checks++;
      if (b.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_b got %b exp 0", b.req_ready); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a.req_ready !== 1'b1 || b.req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %b/%b exp 1/1", a.req_ready, b.req_ready);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) access_a(1'b1, 32'(i) << 2, $urandom, "fill");
   endtask

   task automatic test_write();
      access_a(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "write");
   endtask

   task automatic test_read();
      access_a(1'b0, 32'h0000_0010, $urandom, "read");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         access_a(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, "random");
   endtask

   task automatic test_back_to_back();
      int a0, r0, bz0, gap, lat;
      bit got;
      a0 = acc_n; r0 = resp_n; bz0 = busy_n;
      @(posedge clk); #1;
      a.req_valid = 1'b1; a.req_we = 1'b0; a.req_addr = 32'h4; a.req_wdata = $urandom;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = (acc_n != a0); end
      a.req_addr = 32'h8;
      checks++;
      if (a.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %b exp 0", a.req_ready); end
      for (int k = 0; k < 40 && acc_n < a0 + 2; k++) begin @(posedge clk); #1; end
      a.req_valid = 1'b0;
      for (int k = 0; k < 40 && resp_n < r0 + 2; k++) begin @(posedge clk); #1; end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (!got || acc_n != a0 + 2 || resp_n != r0 + 2) begin
         errors++;
         $display("FAIL b2b_counts got acc=%0d resp=%0d exp 2 2", acc_n - a0, resp_n - r0);
         return;
      end
      gap = acc_edge_a[(a0 + 1) % 256] - acc_edge_a[a0 % 256];
      checks++;
      if (gap != W + 4) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", gap, W + 4); end
      checks++;
      if (busy_n != bz0) begin errors++; $display("FAIL b2b_ready_while_busy got %0d exp 0", busy_n - bz0); end
      checks++;
      if (resp_rd_a[r0 % 256] !== ref_mem[1]) begin
         errors++; $display("FAIL b2b_rdata0 got %h exp %h", resp_rd_a[r0 % 256], ref_mem[1]);
      end
      checks++;
      if (resp_rd_a[(r0 + 1) % 256] !== ref_mem[2]) begin
         errors++; $display("FAIL b2b_rdata1 got %h exp %h", resp_rd_a[(r0 + 1) % 256], ref_mem[2]);
      end
      lat = resp_cyc_a[(r0 + 1) % 256] - acc_edge_a[(a0 + 1) % 256] + 1;
      checks++;
      if (lat != W + 3) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, W + 3); end
      exp_rdata = ref_mem[2];
   endtask

   task automatic test_align();
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      logic [31:0] addrs [2];
      bit          wes   [2];
      addrs[0] = 32'h0000_0012; wes[0] = 1'b0;
      addrs[1] = 32'h0000_0023; wes[1] = 1'b1;
      for (int t = 0; t < 2; t++) begin
         int  a0, r0, c0, w0, lat;
         bit  got;
         a0 = acc_n; r0 = resp_n; c0 = cs_rise_n; w0 = we_n;
         @(posedge clk); #1;
         a.req_valid = 1'b1; a.req_we = wes[t]; a.req_addr = addrs[t]; a.req_wdata = $urandom;
         got = 1'b0;
         for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = (acc_n != a0); end
         a.req_valid = 1'b0;
         for (int k = 0; k < 40 && resp_n == r0; k++) begin @(posedge clk); #1; end
         repeat (2) @(posedge clk);
         #1;
         checks++;
         if (!got || resp_n != r0 + 1) begin
            errors++; $display("FAIL align_handshake got acc=%0d resp=%0d exp 1 1", acc_n - a0, resp_n - r0);
            continue;
         end
         lat = resp_cyc_a[r0 % 256] - acc_edge_a[a0 % 256] + 1;
         checks++;
         if (lat != 1) begin errors++; $display("FAIL align_latency got %0d exp 1", lat); end
         checks++;
         if (resp_err_a[r0 % 256] !== 1'b1) begin
            errors++; $display("FAIL align_err got %b exp 1", resp_err_a[r0 % 256]);
         end
         checks++;
         if (resp_rd_a[r0 % 256] !== exp_rdata) begin
            errors++; $display("FAIL align_rdata got %h exp %h", resp_rd_a[r0 % 256], exp_rdata);
         end
         checks++;
         if (cs_rise_n != c0 || we_n != w0) begin
            errors++; $display("FAIL align_no_cs got cs=%0d we=%0d exp 0 0", cs_rise_n - c0, we_n - w0);
         end
      end
`else
      // without the check, a misaligned address reaches the SRAM untouched
      access_a(1'b1, 32'h0000_0012, $urandom, "unaligned_wr");
      access_a(1'b0, 32'h0000_0010, $urandom, "unaligned_rd");
      access_a(1'b0, 32'h0000_0023, $urandom, "unaligned_rd2");
`endif
   endtask

   task automatic test_reset_mid();
      int a0, r0;
      bit got;
      a0 = acc_n; r0 = resp_n;
      @(posedge clk); #1;
      a.req_valid = 1'b1; a.req_we = 1'b0; a.req_addr = 32'h20; a.req_wdata = $urandom;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin @(posedge clk); #1; got = (acc_n != a0); end
      a.req_valid = 1'b0;
      for (int k = 0; k < 10 && got && a.sram_oe !== 1'b1; k++) begin @(posedge clk); #1; end
      checks++;
      if (!got || a.sram_oe !== 1'b1) begin
         errors++; $display("FAIL rst_mid_reach_access got acc=%b oe=%b exp 1 1", got, a.sram_oe);
         return;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a.sram_cs, a.sram_oe, a.sram_we} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_strobes got %b%b%b exp 000", a.sram_cs, a.sram_oe, a.sram_we);
      end
      checks++;
      if ({a.req_ready, a.resp_valid, a.resp_err} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_ctrl got %b%b%b exp 000", a.req_ready, a.resp_valid, a.resp_err);
      end
      checks++;
      if ({a.resp_rdata, a.sram_addr, a.sram_din} !== 96'b0) begin
         errors++;
         $display("FAIL rst_mid_data got rdata=%h addr=%h din=%h exp 0", a.resp_rdata, a.sram_addr, a.sram_din);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (a.req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_held got %b exp 0", a.req_ready); end
      @(posedge clk); #1;
      checks++;
      if (a.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_release got %b exp 1", a.req_ready); end
      repeat (W + 6) @(posedge clk);
      #1;
      checks++;
      if (resp_n != r0) begin errors++; $display("FAIL rst_mid_dropped got %0d responses exp 0", resp_n - r0); end
      exp_rdata = '0;
   endtask

   task automatic b_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output int oe_c, output int we_c,
                           output logic [31:0] rd, output bit ok);
      int a0, r0, oe0, we0;
      bit got;
      a0 = acc_b_n; r0 = resp_b_n; oe0 = oe_b_n; we0 = we_b_n;
      @(posedge clk); #1;
      b.req_valid = 1'b1; b.req_we = we; b.req_addr = addr; b.req_wdata = wd;
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin @(posedge clk); #1; got = (acc_b_n != a0); end
      b.req_valid = 1'b0;
      for (int k = 0; k < 60 && got && resp_b_n == r0; k++) begin @(posedge clk); #1; end
      repeat (2) @(posedge clk);
      #1;
      ok   = got && (resp_b_n == r0 + 1);
      lat  = resp_b_cyc - acc_b_edge + 1;
      oe_c = oe_b_n - oe0;
      we_c = we_b_n - we0;
      rd   = resp_b_rd;
   endtask

   task automatic test_param();
      int          lat, oe_c, we_c;
      logic [31:0] rd, addr, wd;
      bit          ok;
      addr = 32'($urandom_range(0, 63)) << 2;
      wd   = $urandom;
      b_access(1'b1, addr, wd, lat, oe_c, we_c, rd, ok);
      checks++;
      if (!ok || lat != WB + 3 || we_c != WB || oe_c != 0) begin
         errors++;
         $display("FAIL param_write got ok=%b lat=%0d we=%0d oe=%0d exp 1 %0d %0d 0", ok, lat, we_c, oe_c, WB + 3, WB);
      end
      b_access(1'b0, addr, $urandom, lat, oe_c, we_c, rd, ok);
      checks++;
      if (!ok || lat != WB + 3) begin
         errors++; $display("FAIL param_read_latency got ok=%b lat=%0d exp 1 %0d", ok, lat, WB + 3);
      end
      checks++;
      if (oe_c != WB || we_c != 0) begin
         errors++; $display("FAIL param_read_strobes got oe=%0d we=%0d exp %0d 0", oe_c, we_c, WB);
      end
      checks++;
      if (rd !== wd) begin errors++; $display("FAIL param_read_data got %h exp %h", rd, wd); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_write();
      test_read();
      test_random();
      test_back_to_back();
      test_align();
      test_reset_mid();
      test_read();
      test_random();
      test_param();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
